// File: rtl/yankee_sweeper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : yankee_sweeper_pkg
// Purpose  : Shared widths, constants and FSM encoding for the yankee sweeper.
// Revision : 1.0 - initial release
// ============================================================================
package yankee_sweeper_pkg;

    localparam int X_W = 8;
    localparam int R_W = 16;

    // Start value for the running minimum so the first sample always wins
    localparam logic signed [R_W-1:0] MIN_INIT = 16'sh7FFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/yankee_sweeper_if.sv
`default_nettype none
// ============================================================================
// Module   : yankee_sweeper_if
// Purpose  : Start/ready/valid request bus between the sweeper (master) and
//            one yankeeSolver instance (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface yankee_sweeper_if;
    import yankee_sweeper_pkg::*;

    logic                  sol_start;
    logic signed [X_W-1:0] sol_x;
    logic signed [R_W-1:0] sol_a;
    logic signed [R_W-1:0] sol_b;
    logic signed [R_W-1:0] sol_c;
    logic                  sol_ready;
    logic                  sol_valid;
    logic signed [R_W-1:0] sol_result;

    modport master (
        output sol_start, sol_x, sol_a, sol_b, sol_c,
        input  sol_ready, sol_valid, sol_result
    );

    modport slave (
        input  sol_start, sol_x, sol_a, sol_b, sol_c,
        output sol_ready, sol_valid, sol_result
    );

endinterface
`default_nettype wire

// File: rtl/yankee_sweep_stats.sv
`default_nettype none
// ============================================================================
// Module   : yankee_sweep_stats
// Purpose  : Running minimum (first occurrence) and first-root detection over
//            the stream of captured solver results.
// Revision : 1.0 - initial release
// ============================================================================
module yankee_sweep_stats
    import yankee_sweeper_pkg::*;
(
    input  wire logic                  clock,
    input  wire logic                  reset,
    input  wire logic                  clear_i,
    input  wire logic                  capture_i,
    input  wire logic                  first_i,
    input  wire logic signed [X_W-1:0] x_i,
    input  wire logic signed [R_W-1:0] result_i,
    output logic signed [R_W-1:0]      min_result_o,
    output logic signed [X_W-1:0]      min_x_o,
    output logic                       root_found_o,
    output logic signed [X_W-1:0]      root_x_o
);

    logic signed [R_W-1:0] min_q;
    logic signed [X_W-1:0] min_x_q;
    logic                  root_q;
    logic signed [X_W-1:0] root_x_q;
    logic signed [R_W-1:0] prev_q;

    logic w_zero;
    logic w_flip;
    logic w_new_min;

    // Root/min qualifiers; a zero result wins regardless of the sign history
    always_comb begin
        w_zero    = (result_i == '0);
        w_flip    = !first_i && (prev_q != '0) &&
                    (result_i[R_W-1] != prev_q[R_W-1]);
        w_new_min = (result_i < min_q);
    end

    // Statistics registers, cleared on reset and on every accepted go
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            min_q    <= '0;
            min_x_q  <= '0;
            root_q   <= 1'b0;
            root_x_q <= '0;
            prev_q   <= '0;
        end else if (clear_i) begin
            min_q    <= MIN_INIT;
            min_x_q  <= '0;
            root_q   <= 1'b0;
            root_x_q <= '0;
            prev_q   <= '0;
        end else if (capture_i) begin
            if (w_new_min) begin
                min_q   <= result_i;
                min_x_q <= x_i;
            end
            if (!root_q && (w_zero || w_flip)) begin
                root_q   <= 1'b1;
                root_x_q <= x_i;
            end
            prev_q <= result_i;
        end
    end

    assign min_result_o = min_q;
    assign min_x_o      = min_x_q;
    assign root_found_o = root_q;
    assign root_x_o     = root_x_q;

endmodule
`default_nettype wire

// File: rtl/yankee_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : yankee_sweeper
// Purpose  : Walks x from x_first to x_last, issuing one yankeeSolver request
//            per x, and reports count, minimum and first root of the results.
// Revision : 1.0 - initial release
// ============================================================================
module yankee_sweeper
    import yankee_sweeper_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CW      = 8
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    input  wire logic                  go,
    input  wire logic signed [X_W-1:0] x_first,
    input  wire logic signed [X_W-1:0] x_last,
    input  wire logic signed [R_W-1:0] a_in,
    input  wire logic signed [R_W-1:0] b_in,
    input  wire logic signed [R_W-1:0] c_in,
    yankee_sweeper_if.master           sol,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [8:0]                 count,
    output logic signed [R_W-1:0]      min_result,
    output logic signed [X_W-1:0]      min_x,
    output logic                       root_found,
    output logic signed [X_W-1:0]      root_x
);

    state_t state_q, state_d;

    logic signed [X_W-1:0] cur_x_q, cur_x_d;
    logic signed [X_W-1:0] last_q,  last_d;
    logic signed [R_W-1:0] a_q, a_d;
    logic signed [R_W-1:0] b_q, b_d;
    logic signed [R_W-1:0] c_q, c_d;
    logic signed [R_W-1:0] res_q, res_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [8:0]            count_q, count_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic w_start;
    logic w_clear;
    logic w_capture;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath next values and request strobe
    always_comb begin
        state_d   = state_q;
        cur_x_d   = cur_x_q;
        last_d    = last_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        count_d   = count_q;
        done_d    = 1'b0;
        err_d     = err_q;
        w_start   = 1'b0;
        w_clear   = 1'b0;
        w_capture = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    w_clear = 1'b1;
                    count_d = '0;
                    err_d   = 1'b0;
                    if (x_last >= x_first) begin
                        a_d     = a_in;
                        b_d     = b_in;
                        c_d     = c_in;
                        cur_x_d = x_first;
                        last_d  = x_last;
                        state_d = ST_ISSUE;
                    end else begin
                        // Empty range: finish immediately with cleared stats
                        done_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (sol.sol_ready) begin
                    w_start = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (sol.sol_valid) begin
                    res_d   = sol.sol_result;
                    state_d = ST_CAPTURE;
                end else if (cnt_d == CW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                w_capture = 1'b1;
                count_d   = count_q + 9'd1;
                // Compare before incrementing so x = 127 terminates cleanly
                if (cur_x_q == last_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cur_x_d = cur_x_q + X_W'(1);
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_x_q <= '0;
            last_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cur_x_q <= cur_x_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    yankee_sweep_stats u_stats (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (w_clear),
        .capture_i    (w_capture),
        .first_i      (count_q == 9'd0),
        .x_i          (cur_x_q),
        .result_i     (res_q),
        .min_result_o (min_result),
        .min_x_o      (min_x),
        .root_found_o (root_found),
        .root_x_o     (root_x)
    );

    // Request operands come straight from registers, so they stay stable
    // from the start pulse until the result returns
    assign sol.sol_start = w_start;
    assign sol.sol_x     = cur_x_q;
    assign sol.sol_a     = a_q;
    assign sol.sol_b     = b_q;
    assign sol.sol_c     = c_q;

    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;
    assign error = err_q;
    assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_yankee_sweeper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_yankee_sweeper
// Purpose  : Self-checking bench for yankee_sweeper with a behavioural solver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_yankee_sweeper;
    import yankee_sweeper_pkg::*;

    localparam int TO    = 64;
    localparam int LIMIT = 4000;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  go;
    logic signed [7:0]     x_first, x_last;
    logic signed [15:0]    a_in, b_in, c_in;
    logic                  busy, done, error, root_found;
    logic [8:0]            count;
    logic signed [15:0]    min_result;
    logic signed [7:0]     min_x, root_x;

    int n_cmp   = 0;
    int n_fail  = 0;
    int n_starts = 0;

    yankee_sweeper_if sif();

    yankee_sweeper #(.TIMEOUT(TO), .CW(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .go         (go),
        .x_first    (x_first),
        .x_last     (x_last),
        .a_in       (a_in),
        .b_in       (b_in),
        .c_in       (c_in),
        .sol        (sif),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .count      (count),
        .min_result (min_result),
        .min_x      (min_x),
        .root_found (root_found),
        .root_x     (root_x)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int s16(input int v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    // ---------------- behavioural solver ----------------
    // mode 0: result after slv_lat edges; 1: never answers; 2: valid held high
    int                 slv_mode = 0;
    int                 slv_lat  = 3;
    bit                 slv_abort = 1'b0;
    logic               slv_busy;
    int                 slv_cnt;
    logic signed [7:0]  slv_x;
    logic signed [15:0] slv_a, slv_b, slv_c;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            sif.sol_ready  <= 1'b1;
            sif.sol_valid  <= 1'b0;
            sif.sol_result <= '0;
            slv_busy       <= 1'b0;
            slv_cnt        <= 0;
        end else if (slv_abort) begin
            sif.sol_ready <= 1'b1;
            sif.sol_valid <= 1'b0;
            slv_busy      <= 1'b0;
        end else if (!slv_busy) begin
            sif.sol_valid <= 1'b0;
            sif.sol_ready <= 1'b1;
            if (sif.sol_start && sif.sol_ready) begin
                n_starts++;
                slv_busy      <= 1'b1;
                sif.sol_ready <= 1'b0;
                slv_x <= sif.sol_x;
                slv_a <= sif.sol_a;
                slv_b <= sif.sol_b;
                slv_c <= sif.sol_c;
                slv_cnt <= slv_lat;
                if (slv_mode == 2) begin
                    sif.sol_valid  <= 1'b1;
                    sif.sol_result <= 16'sd7;
                end
            end
        end else if (slv_mode == 0) begin
            if (sif.sol_valid) begin
                sif.sol_valid <= 1'b0;
                sif.sol_ready <= 1'b1;
                slv_busy      <= 1'b0;
            end else if (slv_cnt <= 1) begin
                chk("hold_x", int'(sif.sol_x), int'(slv_x));
                chk("hold_a", int'(sif.sol_a), int'(slv_a));
                sif.sol_valid  <= 1'b1;
                sif.sol_result <= 16'(s16(int'(slv_a) * int'(slv_x) * int'(slv_x)
                                         + int'(slv_b) * int'(slv_x) + int'(slv_c)));
            end else begin
                slv_cnt <= slv_cnt - 1;
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic ref_sweep(input int a, input int b, input int c, input int xf, input int xl,
                             output int cnt, output int rf, output int rx,
                             output int mn, output int mnx);
        int res[$];
        int xs[$];
        for (int x = xf; x <= xl; x++) begin
            res.push_back(s16(a * x * x + b * x + c));
            xs.push_back(x);
        end
        cnt = res.size();
        rf = 0; rx = 0; mn = 32767; mnx = 0;
        foreach (res[i]) if (res[i] < mn) begin mn = res[i]; mnx = xs[i]; end
        foreach (res[i]) begin
            if (rf == 0 && (res[i] == 0 ||
                (i > 0 && res[i-1] != 0 && ((res[i] < 0) != (res[i-1] < 0))))) begin
                rf = 1;
                rx = xs[i];
            end
        end
    endtask

    task automatic do_sweep(input string tag, input int a, input int b, input int c,
                            input int xf, input int xl, input bit poke,
                            input int ecnt, input int erf, input int erx,
                            input int emn, input int emnx);
        int n;
        @(negedge clock);
        a_in = 16'(a); b_in = 16'(b); c_in = 16'(c);
        x_first = 8'(xf); x_last = 8'(xl); go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        n = 0;
        while (!done && n < LIMIT) begin
            if (poke && busy && $urandom_range(0, 15) == 0) begin
                go = 1'b1; x_first = 8'($urandom); x_last = 8'($urandom);
                a_in = 16'($urandom);
            end
            @(negedge clock);
            go = 1'b0;
            n++;
        end
        chk({tag, " done"},       int'(done),       1);
        chk({tag, " count"},      int'(count),      ecnt);
        chk({tag, " root_found"}, int'(root_found), erf);
        chk({tag, " root_x"},     int'(root_x),     erx);
        chk({tag, " min_result"}, int'(min_result), emn);
        chk({tag, " min_x"},      int'(min_x),      emnx);
        chk({tag, " error"},      int'(error),      0);
        chk({tag, " busy"},       int'(busy),       0);
        @(negedge clock);
        chk({tag, " done_pulse"}, int'(done),       0);
    endtask

    task automatic rand_sweep(input string tag, input int a, input int b, input int c,
                              input int xf, input int xl);
        int cnt, rf, rx, mn, mnx;
        ref_sweep(a, b, c, xf, xl, cnt, rf, rx, mn, mnx);
        do_sweep(tag, a, b, c, xf, xl, 1'b1, cnt, rf, rx, mn, mnx);
    endtask

    typedef struct {
        int a, b, c, xf, xl;
        int cnt, rf, rx, mn, mnx;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int n, s0, xf, xl;
        tbl[0] = '{0, 1, 0, -128, 127, 256, 1, 0, -128, -128};
        tbl[1] = '{0, 2, -1, -3, 3, 7, 1, 1, -7, -3};
        tbl[2] = '{0, 0, 5, -3, 3, 7, 0, 0, 5, -3};
        tbl[3] = '{0, 0, 0, 127, 127, 1, 1, 127, 0, 127};
        tbl[4] = '{-1, 0, 0, 126, 127, 2, 0, 0, -16129, 127};
        tbl[5] = '{0, 0, -3, 10, 12, 3, 0, 0, -3, 10};
        tbl[6] = '{1, 0, 0, -2, 2, 5, 1, 0, 0, 0};
        tbl[7] = '{1, 0, -4, -5, 5, 11, 1, -2, -4, 0};

        go = 1'b0; x_first = '0; x_last = '0; a_in = '0; b_in = '0; c_in = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst busy",       int'(busy),          0);
        chk("rst done",       int'(done),          0);
        chk("rst error",      int'(error),         0);
        chk("rst count",      int'(count),         0);
        chk("rst min_result", int'(min_result),    0);
        chk("rst root_found", int'(root_found),    0);
        chk("rst sol_start",  int'(sif.sol_start), 0);
        reset = 1'b0;

        // Table vectors with hand-derived expectations
        for (int i = 0; i < 8; i++) begin
            slv_lat = 3;
            do_sweep($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].xf, tbl[i].xl,
                     (i % 2) == 1, tbl[i].cnt, tbl[i].rf, tbl[i].rx, tbl[i].mn, tbl[i].mnx);
        end

        // Empty range: done one cycle after go, no request issued
        @(negedge clock);
        s0 = n_starts;
        x_first = 8'sd4; x_last = 8'sd2; go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        chk("empty done",       int'(done),       1);
        chk("empty busy",       int'(busy),       0);
        chk("empty count",      int'(count),      0);
        chk("empty min_result", int'(min_result), 32767);
        chk("empty root_found", int'(root_found), 0);
        @(negedge clock);
        chk("empty done_pulse", int'(done), 0);
        repeat (3) @(negedge clock);
        chk("empty no start", n_starts, s0);

        // Timeout: solver never answers
        slv_mode = 1;
        a_in = 16'sd1; x_first = 8'sd0; x_last = 8'sd3; go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        n = 0;
        while (!sif.sol_start && n < 50) begin @(negedge clock); n++; end
        chk("to start seen", int'(sif.sol_start), 1);
        @(posedge clock);
        n = 0;
        do begin
            @(posedge clock);
            n++;
            @(negedge clock);
        end while (!done && n < 4 * TO);
        chk("to latency", n,           TO);
        chk("to error",   int'(error), 1);
        chk("to busy",    int'(busy),  0);
        chk("to count",   int'(count), 0);
        @(negedge clock);
        chk("to done_pulse",   int'(done),  0);
        chk("to error sticky", int'(error), 1);
        slv_abort = 1'b1;
        @(negedge clock);
        slv_abort = 1'b0;
        slv_mode = 0;

        // Randomized sweeps against the reference model
        for (int i = 0; i < 10; i++) begin
            slv_lat = $urandom_range(1, 4);
            xf = $urandom_range(0, 255) - 128;
            xl = xf + $urandom_range(0, 20);
            if (xl > 127) xl = 127;
            if (i < 5)
                rand_sweep($sformatf("rnd%0d", i), $urandom_range(0, 6) - 3,
                           $urandom_range(0, 20) - 10, $urandom_range(0, 100) - 50, xf, xl);
            else
                rand_sweep($sformatf("rnd%0d", i), s16($urandom), s16($urandom),
                           s16($urandom), xf, xl);
        end

        // Reset while waiting with sol_valid high
        slv_mode = 2;
        @(negedge clock);
        a_in = 16'sd1; b_in = 16'sd2; c_in = 16'sd3;
        x_first = 8'sd5; x_last = 8'sd9; go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        n = 0;
        while (!(sif.sol_valid && busy) && n < 50) begin @(negedge clock); n++; end
        chk("mid valid seen", int'(sif.sol_valid && busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("mid busy",       int'(busy),        0);
        chk("mid done",       int'(done),        0);
        chk("mid count",      int'(count),       0);
        chk("mid min_result", int'(min_result),  0);
        chk("mid sol_start",  int'(sif.sol_start), 0);
        chk("mid sol_x",      int'(sif.sol_x),   0);
        chk("mid sol_a",      int'(sif.sol_a),   0);
        @(negedge clock);
        reset = 1'b0;
        slv_mode = 0;
        slv_lat = 3;
        do_sweep("post", tbl[7].a, tbl[7].b, tbl[7].c, tbl[7].xf, tbl[7].xl, 1'b0,
                 tbl[7].cnt, tbl[7].rf, tbl[7].rx, tbl[7].mn, tbl[7].mnx);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
